// File: rtl/axi4_burst_mem_slave.sv
// AXI4 memory slave: MEM_DEPTH x DATA_WIDTH RAM with independent read/write burst engines.
// Write: AW hs -> W beats next cycle -> B one cycle after last W; read: first R beat one cycle after AR hs.
module axi4_burst_mem_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFFW   = $clog2(NBYTES);
    localparam int IDXW   = ADDR_WIDTH - OFFW;
    localparam int MW     = $clog2(MEM_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef logic [IDXW-1:0] idx_t;

    function automatic idx_t next_idx(input idx_t idx, input logic [1:0] burst, input logic [7:0] len);
        idx_t mask;
        mask = idx_t'(len);
        if (burst == BURST_FIXED)
            return idx;
        else if (burst == BURST_WRAP)
            return (idx & ~mask) | ((idx + idx_t'(1)) & mask);
        else
            return idx + idx_t'(1);
    endfunction

    function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'd3) ||
               ((burst == BURST_WRAP) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    function automatic logic in_range(input idx_t idx);
        return (idx >> MW) == '0;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[OFFW-1:0], ARADDR[OFFW-1:0]};

    // ------------------------------------------------------------ write engine
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    w_state_t   w_state, w_next;
    idx_t       w_idx;
    logic [7:0] w_len, w_cnt;
    logic [1:0] w_burst;
    logic       w_berr, w_lerr, w_derr;

    logic aw_hs, w_hs, b_hs, w_last_beat, w_we;
    logic [1:0] bresp_next;

    assign aw_hs       = AWVALID && AWREADY;
    assign w_hs        = WVALID && WREADY;
    assign b_hs        = BVALID && BREADY;
    assign w_last_beat = (w_cnt == w_len);
    assign w_we        = w_hs && !w_berr && in_range(w_idx);

    always_comb begin
        bresp_next = RESP_OKAY;
        if (w_berr || w_lerr || (WLAST != w_last_beat))
            bresp_next = RESP_SLVERR;
        else if (w_derr || !in_range(w_idx))
            bresp_next = RESP_DECERR;
    end

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so no input reaches an output combinationally.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= '0;
            BRESP   <= RESP_OKAY;
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= '0;
            w_berr  <= 1'b0;
            w_lerr  <= 1'b0;
            w_derr  <= 1'b0;
        end else begin
            w_state <= w_next;
            AWREADY <= (w_next == W_IDLE);
            WREADY  <= (w_next == W_DATA);
            BVALID  <= (w_next == W_RESP);
            if (aw_hs) begin
                BID     <= AWID;
                w_idx   <= AWADDR[ADDR_WIDTH-1:OFFW];
                w_len   <= AWLEN;
                w_burst <= AWBURST;
                w_cnt   <= '0;
                w_berr  <= burst_bad(AWBURST, AWLEN);
                w_lerr  <= 1'b0;
                w_derr  <= 1'b0;
            end
            if (w_hs) begin
                w_idx <= next_idx(w_idx, w_burst, w_len);
                w_cnt <= w_cnt + 8'd1;
                if (WLAST != w_last_beat) w_lerr <= 1'b1;
                if (!in_range(w_idx))     w_derr <= 1'b1;
                if (w_last_beat)          BRESP  <= bresp_next;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (WSTRB[b]) mem[w_idx[MW-1:0]][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------- read engine
    typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;
    r_state_t   r_state, r_next;
    idx_t       r_idx, fetch_idx;
    logic [7:0] r_len, r_cnt;
    logic [1:0] r_burst;
    logic       r_berr, fetch_err;
    logic       ar_hs, r_hs, r_load;

    assign ar_hs  = ARVALID && ARREADY;
    assign r_hs   = RVALID && RREADY;
    assign r_load = ar_hs || (r_hs && !RLAST);

    always_comb begin
        fetch_idx = next_idx(r_idx, r_burst, r_len);
        fetch_err = r_berr;
        if (ar_hs) begin
            fetch_idx = ARADDR[ADDR_WIDTH-1:OFFW];
            fetch_err = burst_bad(ARBURST, ARLEN);
        end
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && RLAST) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // RAM is sampled before any same-edge write lands, so a colliding read sees the old word.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RID     <= '0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
            r_berr  <= 1'b0;
        end else begin
            r_state <= r_next;
            ARREADY <= (r_next == R_IDLE);
            RVALID  <= (r_next == R_DATA);
            if (ar_hs) begin
                RID     <= ARID;
                r_len   <= ARLEN;
                r_burst <= ARBURST;
                r_berr  <= burst_bad(ARBURST, ARLEN);
                r_cnt   <= '0;
                RLAST   <= (ARLEN == 8'd0);
            end else if (r_hs) begin
                r_cnt <= r_cnt + 8'd1;
                RLAST <= !RLAST && ((r_cnt + 8'd1) == r_len);
            end
            if (r_load) begin
                r_idx <= fetch_idx;
                if (fetch_err) begin
                    RDATA <= '0;
                    RRESP <= RESP_SLVERR;
                end else if (!in_range(fetch_idx)) begin
                    RDATA <= '0;
                    RRESP <= RESP_DECERR;
                end else begin
                    RDATA <= mem[fetch_idx[MW-1:0]];
                    RRESP <= RESP_OKAY;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed bench for axi4_burst_mem_slave: bursts, strobes, error responses, stalls and reset.
module tb_axi4_burst_mem_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWID, BID, ARID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    always #5 ACLK = ~ACLK;

    axi4_burst_mem_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] wbuf  [256];
    logic [3:0]  sbuf  [256];
    logic [31:0] exp_d [256];
    logic [1:0]  exp_r [256];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_strb();
        for (int i = 0; i < 256; i++) sbuf[i] = 4'hF;
    endtask

    // Entered and left just after a rising edge.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int wlast_at, input bit stall,
                            input logic [1:0] exp_resp, input string tag);
        int n;
        bit got;
        logic [3:0] bid_s;
        logic [1:0] bresp_s;
        AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!AWREADY && n < 200) begin @(negedge ACLK); n++; end
        chk({tag, "_awready"}, AWREADY, 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WVALID = 1'b1; WDATA = wbuf[i]; WSTRB = sbuf[i]; WLAST = (i == wlast_at);
            n = 0;
            @(negedge ACLK);
            while (!WREADY && n < 200) begin @(negedge ACLK); n++; end
            if (!WREADY) chk({tag, "_wready"}, WREADY, 1);
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        n = 0; got = 0; bid_s = '0; bresp_s = '0;
        while (!got && n < 2000) begin
            BREADY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge ACLK);
            if (BVALID && BREADY) begin got = 1; bid_s = BID; bresp_s = BRESP; end
            @(posedge ACLK); #1;
            n++;
        end
        BREADY = 1'b0;
        chk({tag, "_bseen"}, got, 1);
        chk({tag, "_bresp"}, bresp_s, exp_resp);
        chk({tag, "_bid"}, bid_s, id);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit stall, input string tag);
        int n;
        int beat;
        ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!ARREADY && n < 200) begin @(negedge ACLK); n++; end
        chk({tag, "_arready"}, ARREADY, 1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        beat = 0; n = 0;
        while (beat <= int'(len) && n < 3000) begin
            RREADY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge ACLK);
            if (RVALID) begin
                chk({tag, "_rdata"}, RDATA, exp_d[beat]);
                chk({tag, "_rresp"}, RRESP, exp_r[beat]);
                chk({tag, "_rlast"}, RLAST, (beat == int'(len)));
                chk({tag, "_rid"}, RID, id);
                if (RREADY) beat++;
            end
            @(posedge ACLK); #1;
            n++;
        end
        RREADY = 1'b0;
        chk({tag, "_beats"}, beat, int'(len) + 1);
    endtask

    initial begin
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
        clear_strb();
        #1;
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rlast", RLAST, 0);
        chk("rst_outs", {BID, BRESP, RID, RDATA, RRESP}, 0);
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        @(negedge ACLK);
        chk("rel_awready_before_edge", AWREADY, 0);
        @(posedge ACLK); #1;
        chk("rel_awready", AWREADY, 1);
        chk("rel_arready", ARREADY, 1);

        // INCR write then read back
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
        do_write(4'h3, 32'h10, 8'd3, 2'd1, 3, 0, 2'd0, "incr_wr");
        for (int i = 0; i < 4; i++) begin exp_d[i] = 32'hA0 + i; exp_r[i] = 2'd0; end
        do_read(4'h5, 32'h10, 8'd3, 2'd1, 0, "incr_rd");

        // WRAP read over words 0..3
        for (int i = 0; i < 4; i++) wbuf[i] = i;
        do_write(4'h1, 32'h00, 8'd3, 2'd1, 3, 0, 2'd0, "fill0");
        exp_d[0] = 2; exp_d[1] = 3; exp_d[2] = 0; exp_d[3] = 1;
        for (int i = 0; i < 4; i++) exp_r[i] = 2'd0;
        do_read(4'h6, 32'h08, 8'd3, 2'd2, 0, "wrap_rd");
        for (int i = 0; i < 3; i++) begin exp_d[i] = 0; exp_r[i] = 2'd2; end
        do_read(4'h7, 32'h08, 8'd2, 2'd2, 0, "wrap_bad_rd");
        for (int i = 0; i < 3; i++) wbuf[i] = 32'h77;
        do_write(4'h2, 32'h00, 8'd2, 2'd2, 2, 0, 2'd2, "wrap_bad_wr");
        for (int i = 0; i < 4; i++) begin exp_d[i] = i; exp_r[i] = 2'd0; end
        do_read(4'h8, 32'h00, 8'd3, 2'd1, 0, "wrap_bad_nowrite");
        for (int i = 0; i < 2; i++) begin exp_d[i] = 0; exp_r[i] = 2'd2; end
        do_read(4'h9, 32'h00, 8'd1, 2'd3, 0, "rsvd_rd");

        // Byte strobes
        wbuf[0] = 32'hDEADBEEF;
        do_write(4'h4, 32'h20, 8'd0, 2'd1, 0, 0, 2'd0, "strb_wr0");
        wbuf[0] = 32'h000000FF; sbuf[0] = 4'h1;
        do_write(4'h4, 32'h20, 8'd0, 2'd1, 0, 0, 2'd0, "strb_wr1");
        clear_strb();
        exp_d[0] = 32'hDEADBEFF; exp_r[0] = 2'd0;
        do_read(4'h4, 32'h20, 8'd0, 2'd1, 0, "strb_rd");

        // FIXED burst lands every beat on one word
        for (int i = 0; i < 4; i++) wbuf[i] = i + 1;
        do_write(4'hA, 32'h30, 8'd3, 2'd0, 3, 0, 2'd0, "fixed_wr");
        exp_d[0] = 4; exp_r[0] = 2'd0;
        do_read(4'hA, 32'h30, 8'd0, 2'd1, 0, "fixed_rd");

        // WLAST on the wrong beat; out-of-range tail
        wbuf[0] = 32'h11; wbuf[1] = 32'h22;
        do_write(4'hB, 32'h50, 8'd1, 2'd1, 0, 0, 2'd2, "wlast_err");
        wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002;
        do_write(4'hC, 32'h3FC, 8'd1, 2'd1, 1, 0, 2'd3, "decerr_wr");
        exp_d[0] = 32'hCAFE0001; exp_r[0] = 2'd0;
        do_read(4'hC, 32'h3FC, 8'd0, 2'd1, 0, "decerr_word_rd");

        // Full-memory fill, then concurrent 256-beat write and read under stalls
        for (int i = 0; i < 256; i++) wbuf[i] = 32'h1000 + i;
        do_write(4'hD, 32'h0, 8'd255, 2'd1, 255, 0, 2'd0, "fill_all");
        for (int i = 0; i < 256; i++) wbuf[i] = 32'h5000 + i;
        for (int i = 0; i < 255; i++) begin exp_d[i] = 32'h1000 + i + 1; exp_r[i] = 2'd0; end
        exp_d[255] = 0; exp_r[255] = 2'd3;
        fork
            do_write(4'hE, 32'h0, 8'd255, 2'd0, 255, 1, 2'd0, "conc_wr");
            do_read(4'hF, 32'h4, 8'd255, 2'd1, 1, "conc_rd");
        join
        exp_d[0] = 32'h50FF; exp_r[0] = 2'd0;
        do_read(4'h1, 32'h0, 8'd0, 2'd1, 0, "conc_fixed_rd");

        // Reset in the middle of a read burst
        ARID = 4'h9; ARADDR = 32'h40; ARLEN = 8'd15; ARBURST = 2'd1; ARVALID = 1'b1; RREADY = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge ACLK);
            while (!ARREADY && n < 200) begin @(negedge ACLK); n++; end
            chk("mid_rst_arready", ARREADY, 1);
        end
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        @(posedge ACLK); @(posedge ACLK); #1;
        chk("mid_rst_pre_rvalid", RVALID, 1);
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_rvalid", RVALID, 0);
        chk("mid_rst_arready_low", ARREADY, 0);
        chk("mid_rst_rlast", RLAST, 0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1; RREADY = 1'b0;
        @(posedge ACLK); #1;
        chk("post_rst_arready", ARREADY, 1);
        chk("post_rst_rvalid", RVALID, 0);
        exp_d[0] = 32'h1010; exp_r[0] = 2'd0;
        do_read(4'h2, 32'h40, 8'd0, 2'd1, 0, "post_rst_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
